// File: rtl/if_id_pipereg.sv
// IF/ID pipeline register: pairs each fetched instruction with its PC, presents it to
// decode with a valid bit, absorbs one instruction during a stall and bubbles on flush.
module if_id_pipereg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC_in,
  input  logic [DATA_W-1:0] IDATA,
  input  logic              IVALID,
  input  logic              Stall,
  input  logic              Flush,
  output logic [DATA_W-1:0] INSTR_out,
  output logic [ADDR_W-1:0] PC_out,
  output logic [ADDR_W-1:0] NPC_out,
  output logic              VALID_out,
  output logic              BUF_FULL,
  output logic              OVF_ERR,
  output logic [CNT_W-1:0]  DLV_CNT
);

  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] pc_r;
  logic              valid_r;
  logic [DATA_W-1:0] binstr_r;
  logic [ADDR_W-1:0] bpc_r;
  logic              bvalid_r;
  logic              ovf_r;
  logic [CNT_W-1:0]  cnt_r;

  // Output register, hold buffer, overflow flag and delivery counter; RST > Flush > Stall > advance
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_r  <= NOP_INSTR;
      pc_r     <= '0;
      valid_r  <= 1'b0;
      binstr_r <= NOP_INSTR;
      bpc_r    <= '0;
      bvalid_r <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= '0;
    end else if (Flush) begin
      instr_r  <= NOP_INSTR;
      valid_r  <= 1'b0;
      bvalid_r <= 1'b0;
    end else if (Stall) begin
      if (IVALID) begin
        if (bvalid_r) begin
          ovf_r <= 1'b1;
        end else begin
          binstr_r <= IDATA;
          bpc_r    <= PC_in;
          bvalid_r <= 1'b1;
        end
      end
    end else if (bvalid_r) begin
      // Buffered (older) word goes first so arrival order is preserved
      instr_r <= binstr_r;
      pc_r    <= bpc_r;
      valid_r <= 1'b1;
      cnt_r   <= cnt_r + CNT_W'(1);
      if (IVALID) begin
        binstr_r <= IDATA;
        bpc_r    <= PC_in;
      end else begin
        bvalid_r <= 1'b0;
      end
    end else if (IVALID) begin
      instr_r <= IDATA;
      pc_r    <= PC_in;
      valid_r <= 1'b1;
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end
  end

  assign INSTR_out = instr_r;
  assign PC_out    = pc_r;
  assign NPC_out   = pc_r + ADDR_W'(4);
  assign VALID_out = valid_r;
  assign BUF_FULL  = bvalid_r;
  assign OVF_ERR   = ovf_r;
  assign DLV_CNT   = cnt_r;

endmodule

// File: doc/if_id_pipereg.md
Name: if_id_pipereg

Overview:
- Pipeline register between the instruction-fetch stage and the decode stage of the RISC-TOY core.
- Pairs each fetched instruction word from instruction memory with the PC of the fetch that produced it.
- Presents the pair, with a valid bit, to decode.
- Absorbs one instruction that arrives while decode is stalled, using a single-entry hold buffer, and inserts a NOP bubble on a branch/jump flush.

Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 32, PC width
- NOP_INSTR, 32'h0000_0000, word driven on INSTR_out when the stage holds a bubble
- CNT_W, 16, width of the delivered-instruction counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- PC_in  in  ADDR_W  PC of the fetch whose data is on IDATA (from the IF stage PC register)
- IDATA  in  DATA_W  instruction word from instruction memory
- IVALID  in  1  IDATA/PC_in carry a real fetched instruction this cycle
- Stall  in  1  decode/hazard unit: hold outputs this cycle
- Flush  in  1  branch/jump taken: discard everything held in this stage
- INSTR_out  out  DATA_W  instruction to decode
- PC_out  out  ADDR_W  PC of INSTR_out
- NPC_out  out  ADDR_W  PC_out + 4, wraps modulo 2^ADDR_W
- VALID_out  out  1  INSTR_out/PC_out hold a real instruction
- BUF_FULL  out  1  hold buffer occupied; IF treats it as an additional stall source
- OVF_ERR  out  1  sticky; an instruction arrived while stalled with the buffer already full
- DLV_CNT  out  CNT_W  number of instructions delivered to decode, wraps

Behaviour:
- State: output register (INSTR, PC, VALID), one-entry hold buffer (BINSTR, BPC, BVALID), OVF_ERR, DLV_CNT.
- Reset values: INSTR_out=NOP_INSTR, PC_out=0, NPC_out=4, VALID_out=0, BUF_FULL=0, OVF_ERR=0, DLV_CNT=0.
- Reset is synchronous and overrides all other inputs, including reset asserted mid-stall with the buffer full.
- Priority each edge: RST > Flush > Stall > normal advance.
- Flush: VALID_out<=0, INSTR_out<=NOP_INSTR, PC_out unchanged, BVALID<=0.
  - An IVALID in the same cycle is discarded.
  - Flush+Stall in the same cycle: flush wins.
  - DLV_CNT is unchanged and OVF_ERR is not set.
- Stall, no flush: output register holds.
  - IVALID=1 and BVALID=0: capture IDATA/PC_in into the buffer, BVALID<=1.
  - IVALID=1 and BVALID=1: new word dropped, buffer keeps its older entry, OVF_ERR<=1.
- Normal advance, BVALID=1: buffer contents move to the outputs, VALID_out<=1.
  - If IVALID=1 the buffer reloads with the new word (stays full); otherwise BVALID<=0.
- Normal advance, BVALID=0: outputs load IDATA/PC_in.
  - VALID_out<=IVALID.
  - When IVALID=0, INSTR_out<=NOP_INSTR and PC_out holds.
- Ordering: instructions reach the outputs strictly in arrival order. Latency is 1 cycle from IVALID to the outputs when not stalled and the buffer is empty.
- NPC_out is combinational from PC_out (PC_out+4).
- DLV_CNT increments by 1 on every edge where VALID_out is loaded with 1 by a normal advance; it wraps from 2^CNT_W-1 to 0.
- OVF_ERR clears only on RST.
- BUF_FULL equals BVALID, with no combinational path from inputs.

Test Plan:
- Reset then stream: RST high 2 cycles, then IVALID=1 with PC 0x0,0x4,0x8 and IDATA 0x11,0x22,0x33 -> outputs show each pair one cycle later, NPC_out=0x4,0x8,0xC, DLV_CNT=3.
- Stall capture: Stall=1 while 0x44@PC 0x10 arrives -> outputs hold the prior instruction and BUF_FULL=1; release Stall with IVALID=0 -> INSTR_out=0x44, PC_out=0x10, BUF_FULL=0.
- Overflow: Stall=1 for 3 cycles with IVALID=1 every cycle (0x55,0x66,0x77) -> buffer keeps 0x55, OVF_ERR=1 from the 2nd word onward; after release INSTR_out=0x55.
- Flush vs stall: buffer full (0x88), assert Flush+Stall+IVALID (0x99) in one cycle -> VALID_out=0, INSTR_out=NOP_INSTR, BUF_FULL=0, DLV_CNT unchanged.
- Wrap: CNT_W=4, deliver 17 instructions -> DLV_CNT=1. PC_in=0xFFFF_FFFC -> NPC_out=0x0000_0000.
- Reset mid-operation: buffer full and OVF_ERR=1, RST=1 for one edge -> all outputs at reset values on that edge.
